// File: rtl/chart_recorder.sv
// chart_recorder: records a 3-lane button chart into a step memory
// that the LED playback path reads through rd_addr/rd_data.
//
// Ports:
//   sysclk, reset (sync, active-low)
//   start, stop             : level-sampled record controls
//   button0..2              : raw async lane buttons (right, middle, left)
//   rd_addr / rd_data       : registered read port, 1-cycle latency
//   armed/recording/done    : one-hot state flags (all 0 in IDLE)
//   step_count              : number of steps written in this take
//
// Build option: define CHART_RECORDER_ROUND_EN to push late presses
// (second half of a step) into the following step.
module chart_recorder #(
    parameter int STEPS           = 89,
    parameter int STEP_CYCLES     = 16777216,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       button0,
    input  logic       button1,
    input  logic       button2,
    input  logic [6:0] rd_addr,
    output logic [2:0] rd_data,
    output logic       armed,
    output logic       recording,
    output logic       done,
    output logic [6:0] step_count
);

    localparam int IW = (STEPS > 2) ? $clog2(STEPS) : 1;
    localparam int TW = $clog2(STEP_CYCLES);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [TW-1:0] TLAST = TW'(STEP_CYCLES - 1);
    localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]    FULL1 = 8'(STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_REC,
        S_DONE
    } state_t;

    logic [2:0]    raw;
    logic [2:0]    s1_q;
    logic [2:0]    s2_q;
    logic [2:0]    press;
    logic [2:0]    early;
    logic [2:0]    late;

    state_t        state_q;
    logic          armed_q;
    logic          rec_q;
    logic          done_q;
    logic [7:0]    count_q;
    logic [TW-1:0] timer_q;
    logic [2:0]    cur_q;
    logic [2:0]    nxt_q;
    logic [2:0]    rd_q;
    logic [2:0]    mem_q [STEPS];

    logic          step_end;
    logic          last_step;
    logic          wr_en;

    assign raw = {button2, button1, button0};

    // Two-flop synchronizer for the raw buttons.
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= raw;
            s2_q <= s1_q;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_lane
        logic [DW-1:0] cnt_q;
        logic          deb_q;

        // Counts consecutive cycles of disagreement; any agreement restarts.
        always_ff @(posedge sysclk) begin
            if (!reset) begin
                cnt_q <= '0;
                deb_q <= 1'b0;
            end else if (s2_q[i] != deb_q) begin
                if (cnt_q == DLAST) begin
                    deb_q <= s2_q[i];
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end

        // Press fires in the cycle the debounced level is about to rise.
        assign press[i] = s2_q[i] & ~deb_q & (cnt_q == DLAST);
    end

`ifdef CHART_RECORDER_ROUND_EN
    localparam logic [TW-1:0] THALF = TW'(STEP_CYCLES / 2);

    always_comb begin
        late  = (timer_q >= THALF) ? press : 3'b000;
        early = press & ~late;
    end
`else
    always_comb begin
        late  = 3'b000;
        early = press;
    end
`endif

    assign step_end  = (timer_q == TLAST);
    assign last_step = (count_q == FULL1);
    assign wr_en     = (state_q == S_REC) && (stop || step_end);

    always_ff @(posedge sysclk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            armed_q <= 1'b0;
            rec_q   <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
            timer_q <= '0;
            cur_q   <= '0;
            nxt_q   <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_ARMED;
                        armed_q <= 1'b1;
                        count_q <= '0;
                        cur_q   <= '0;
                        nxt_q   <= '0;
                    end
                end
                S_ARMED: begin
                    if (stop) begin
                        state_q <= S_IDLE;
                        armed_q <= 1'b0;
                        count_q <= '0;
                    end else if (|press) begin
                        // The arming press is cycle 0 of step 0.
                        state_q <= S_REC;
                        armed_q <= 1'b0;
                        rec_q   <= 1'b1;
                        cur_q   <= press;
                        nxt_q   <= '0;
                        timer_q <= TW'(1);
                    end
                end
                S_REC: begin
                    if (stop || step_end) begin
                        count_q <= count_q + 8'd1;
                        timer_q <= '0;
                        if (stop || last_step) begin
                            state_q <= S_DONE;
                            rec_q   <= 1'b0;
                            done_q  <= 1'b1;
                            cur_q   <= '0;
                            nxt_q   <= '0;
                        end else begin
                            // A press on the write cycle belongs to the next step.
                            cur_q <= nxt_q | press;
                            nxt_q <= '0;
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                        cur_q   <= cur_q | early;
                        nxt_q   <= nxt_q | late;
                    end
                end
                S_DONE: begin
                    if (start) begin
                        state_q <= S_ARMED;
                        done_q  <= 1'b0;
                        armed_q <= 1'b1;
                        count_q <= '0;
                        cur_q   <= '0;
                        nxt_q   <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Step memory is never reset; step_count masks stale entries.
    always_ff @(posedge sysclk) begin
        if (wr_en) begin
            mem_q[count_q[IW-1:0]] <= cur_q;
        end
    end

    always_ff @(posedge sysclk) begin
        if (!reset) begin
            rd_q <= '0;
        end else if ({1'b0, rd_addr} < count_q) begin
            rd_q <= mem_q[rd_addr[IW-1:0]];
        end else begin
            rd_q <= '0;
        end
    end

    assign rd_data    = rd_q;
    assign armed      = armed_q;
    assign recording  = rec_q;
    assign done       = done_q;
    assign step_count = count_q[6:0];

endmodule
